// File: rtl/mac_mp_pkg.sv
// rtl/mac_mp_pkg.sv - shared types and pass-sequencing helpers for mac_unit_mp
package mac_mp_pkg;

    typedef enum logic [1:0] {
        MODE_8x8   = 2'd0,
        MODE_8x16  = 2'd1,
        MODE_16x16 = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    typedef struct packed {
        logic a_hi;
        logic b_hi;
    } pass_sel_t;

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_8x16;
            2'd2:    return MODE_16x16;
            default: return MODE_8x8;
        endcase
    endfunction

    function automatic logic [2:0] passes_for_mode(input mode_e m);
        case (m)
            MODE_8x16:  return 3'd2;
            MODE_16x16: return 3'd4;
            default:    return 3'd1;
        endcase
    endfunction

    // Pass order lo*lo, lo*hi(b), hi(a)*lo, hi*hi falls out of the pass index bits.
    function automatic pass_sel_t pass_select(input logic [1:0] p);
        pass_sel_t s;
        s.a_hi = p[1];
        s.b_hi = p[0];
        return s;
    endfunction

    function automatic int pass_shift(input logic [1:0] p, input int iw, input int ww);
        return (p[1] ? iw : 0) + (p[0] ? ww : 0);
    endfunction

endpackage

// File: rtl/mac_unit_mp_if.sv
// rtl/mac_unit_mp_if.sv - operand, weight and result bus of mac_unit_mp
interface mac_unit_mp_if #(
    parameter int LANES = 2,
    parameter int I_W   = 8,
    parameter int W_W   = 8,
    parameter int RES_W = 32,
    parameter int CNT_W = 8
);
    logic [1:0]               mode;
    logic                     a_s;
    logic                     b_s;
    logic [CNT_W-1:0]         acc_len;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*2*I_W-1:0]   in_data;
    logic [LANES*W_W-1:0]     W_in;
    logic                     W_en;
    logic [LANES*W_W-1:0]     W_out;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*RES_W-1:0]   res_out;
    logic                     busy;

    modport master (
        output mode, a_s, b_s, acc_len, in_valid, in_data, W_in, W_en, out_ready,
        input  in_ready, W_out, out_valid, res_out, busy
    );

    modport slave (
        input  mode, a_s, b_s, acc_len, in_valid, in_data, W_in, W_en, out_ready,
        output in_ready, W_out, out_valid, res_out, busy
    );
endinterface

// File: rtl/mac_mp_lane.sv
// rtl/mac_mp_lane.sv - one MAC lane: weight store, partial-product multiplier, accumulator
module mac_mp_lane
    import mac_mp_pkg::*;
#(
    parameter int I_W   = 8,
    parameter int W_W   = 8,
    parameter int W_D   = 4,
    parameter int RES_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a_load,
    input  logic [2*I_W-1:0]   a_in,
    input  logic               mul_en,
    input  logic [1:0]         pass,
    input  mode_e              mode,
    input  logic               a_s,
    input  logic               b_s,
    input  logic               ptr_adv,
    input  logic               acc_clr,
    input  logic               w_load,
    input  logic [W_W-1:0]     w_in,
    output logic [W_W-1:0]     w_out,
    output logic [RES_W-1:0]   res
);
    localparam int PW = (W_D > 1) ? $clog2(W_D) : 1;
    localparam int PP = I_W + W_W + 2;
    localparam logic [PW:0] ONE_C = (PW+1)'(1);
    localparam logic [PW:0] TWO_C = (PW+1)'(2);
    localparam logic [PW:0] WD_C  = (PW+1)'(W_D);

    logic [W_W-1:0]   word_q [W_D];
    logic [W_W-1:0]   word_d [W_D];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [2*I_W-1:0] a_q, a_d;
    logic [RES_W-1:0] acc_q, acc_d;

    pass_sel_t         sel;
    logic [PW:0]       ptr_hi_sum, ptr_nxt_sum;
    logic [PW-1:0]     ptr_hi;
    logic [I_W-1:0]    a_half;
    logic [W_W-1:0]    b_half;
    logic              a_sgn, b_sgn;
    logic signed [PP-1:0] a_ext, b_ext, prod;
    logic [RES_W-1:0]  prod_ext;

    always_comb begin
        sel = pass_select(pass);

        ptr_hi_sum = {1'b0, ptr_q} + ONE_C;
        if (ptr_hi_sum >= WD_C) ptr_hi_sum = ptr_hi_sum - WD_C;
        ptr_hi = ptr_hi_sum[PW-1:0];

        ptr_nxt_sum = {1'b0, ptr_q} + ((mode == MODE_8x8) ? ONE_C : TWO_C);
        if (ptr_nxt_sum >= WD_C) ptr_nxt_sum = ptr_nxt_sum - WD_C;

        a_half = sel.a_hi ? a_q[2*I_W-1:I_W] : a_q[I_W-1:0];
        b_half = sel.b_hi ? word_q[ptr_hi] : word_q[ptr_q];

        // Lo halves of split operands are magnitude bits; unsplit operands carry the sign.
        a_sgn = (mode == MODE_16x16) ? (sel.a_hi & a_s) : a_s;
        b_sgn = (mode == MODE_8x8) ? b_s : (sel.b_hi & b_s);

        a_ext    = {{(PP-I_W){a_sgn & a_half[I_W-1]}}, a_half};
        b_ext    = {{(PP-W_W){b_sgn & b_half[W_W-1]}}, b_half};
        prod     = a_ext * b_ext;
        prod_ext = {{(RES_W-PP){prod[PP-1]}}, prod};
    end

    always_comb begin
        word_d = word_q;
        ptr_d  = ptr_q;
        a_d    = a_q;
        acc_d  = acc_q;
        if (w_load) begin
            word_d[0] = w_in;
            for (int i = 1; i < W_D; i++) word_d[i] = word_q[i-1];
            ptr_d = '0;
        end
        if (a_load) a_d = a_in;
        if (mul_en) acc_d = acc_q + (prod_ext << pass_shift(pass, I_W, W_W));
        if (ptr_adv) ptr_d = ptr_nxt_sum[PW-1:0];
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < W_D; i++) word_q[i] <= '0;
            ptr_q <= '0;
            a_q   <= '0;
            acc_q <= '0;
        end else begin
            for (int i = 0; i < W_D; i++) word_q[i] <= word_d[i];
            ptr_q <= ptr_d;
            a_q   <= a_d;
            acc_q <= acc_d;
        end
    end

    assign w_out = word_q[W_D-1];
    assign res   = acc_q;

endmodule

// File: rtl/mac_unit_mp.sv
// rtl/mac_unit_mp.sv - multi-lane multi-precision MAC: shared sequencer over LANES lanes
module mac_unit_mp
    import mac_mp_pkg::*;
#(
    parameter int LANES = 2,
    parameter int I_W   = 8,
    parameter int W_W   = 8,
    parameter int W_D   = 4,
    parameter int RES_W = 32,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mac_unit_mp_if.slave  bus
);
    state_e           state_q;
    logic [1:0]       pass_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_m1_q;
    mode_e            mode_q;
    logic             a_s_q, b_s_q;
    logic             in_ready_q, out_valid_q;

    logic             accept, mul_en, last_pass, acc_clr, w_load;
    logic [LANES*W_W-1:0]   w_out_all;
    logic [LANES*RES_W-1:0] res_all;

    always_comb begin
        accept    = (state_q == S_IDLE) && bus.in_valid;
        mul_en    = (state_q == S_MUL);
        last_pass = mul_en && ({1'b0, pass_q} == (passes_for_mode(mode_q) - 3'd1));
        acc_clr   = (state_q == S_OUT) && bus.out_ready;
        w_load    = (state_q == S_IDLE) && (cnt_q == '0) && bus.W_en;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pass_q      <= '0;
            cnt_q       <= '0;
            len_m1_q    <= '0;
            mode_q      <= MODE_8x8;
            a_s_q       <= 1'b0;
            b_s_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_q    <= S_MUL;
                        pass_q     <= '0;
                        in_ready_q <= 1'b0;
                        // Group configuration is frozen at the first input of a group.
                        if (cnt_q == '0) begin
                            mode_q   <= decode_mode(bus.mode);
                            a_s_q    <= bus.a_s;
                            b_s_q    <= bus.b_s;
                            len_m1_q <= (bus.acc_len == '0) ? '0 : bus.acc_len - CNT_W'(1);
                        end
                    end
                end
                S_MUL: begin
                    if (last_pass) begin
                        pass_q <= '0;
                        if (cnt_q == len_m1_q) begin
                            cnt_q       <= '0;
                            state_q     <= S_OUT;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt_q      <= cnt_q + CNT_W'(1);
                            state_q    <= S_IDLE;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        pass_q <= pass_q + 2'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mac_mp_lane #(
            .I_W   (I_W),
            .W_W   (W_W),
            .W_D   (W_D),
            .RES_W (RES_W)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .a_load  (accept),
            .a_in    (bus.in_data[k*2*I_W +: 2*I_W]),
            .mul_en  (mul_en),
            .pass    (pass_q),
            .mode    (mode_q),
            .a_s     (a_s_q),
            .b_s     (b_s_q),
            .ptr_adv (last_pass),
            .acc_clr (acc_clr),
            .w_load  (w_load),
            .w_in    (bus.W_in[k*W_W +: W_W]),
            .w_out   (w_out_all[k*W_W +: W_W]),
            .res     (res_all[k*RES_W +: RES_W])
        );
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.W_out     = w_out_all;
    assign bus.res_out   = res_all;
    assign bus.busy      = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: doc/mac_unit_mp.md
Name: mac_unit_mp

Overview:
Multi-lane, multi-precision MAC. This is the next generation of the single-lane 8x8 MAC tile. LANES identical datapaths share one sequencer. Each lane computes 8x8, 8x16 or 16x16 products by sequencing I_W x W_W partial products through one multiplier, shifting and accumulating them. Inputs and results use valid/ready handshakes, and each lane has a shift-loaded weight store with cascade output for chaining tiles.

Parameters:
LANES, 2, number of parallel lanes sharing control
I_W, 8, input half-operand width (full input = 2*I_W)
W_W, 8, weight word width
W_D, 4, weight words per lane (even, >=2)
RES_W, 32, accumulator/result width (>= 2*(I_W+W_W))
CNT_W, 8, width of acc_len

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mode  in  2  0=8x8, 1=8x16 (16-bit weight), 2=16x16; 3 reserved, treated as 0
a_s  in  1  input operand signed
b_s  in  1  weight operand signed
acc_len  in  CNT_W  products per result; 0 treated as 1
in_valid  in  1  input data valid
in_ready  out  1  block accepts input
in_data  in  LANES*2*I_W  per-lane input; lane k at [k*2*I_W +: 2*I_W]; 8x8 and 8x16 use the low I_W bits only
W_in  in  LANES*W_W  per-lane weight shift-in
W_en  in  1  weight shift enable
W_out  out  LANES*W_W  per-lane cascade = word[W_D-1]
out_valid  out  1  result valid
out_ready  in  1  result consumed
res_out  out  LANES*RES_W  per-lane accumulated result
busy  out  1  state != S_IDLE or group count != 0

Behaviour:
- Reset (async, active-high): state=S_IDLE, all weight words=0, ptr=0, group count=0, accumulators=0. Outputs after reset: in_ready=1, out_valid=0, res_out=0, W_out=0, busy=0.
- mode, a_s, b_s and acc_len are latched on the accepted handshake that has group count==0. They are held for the whole group; changes mid-group are ignored.
- Passes per input P: mode0=1, mode1=2, mode2=4.
- FSM:
  - S_IDLE: in_ready=1. On in_valid: latch operands per lane and go to S_MUL with pass=0.
  - S_MUL: in_ready=0. One partial product per cycle, pass increments. After pass P-1: if count==acc_len_eff-1, count=0 and go to S_OUT; else count+=1 and go to S_IDLE.
  - S_OUT: out_valid=1, res_out stable. On out_ready: clear accumulators and go to S_IDLE. out_valid falls the cycle after the handshake.
- Throughput is one input per P+1 cycles. A result appears the cycle after the last pass of the last input.
- Partial products: a_lo/a_hi = in_data halves; b_lo=word[ptr], b_hi=word[ptr+1].
  - Pass order: (a_lo,b_lo,<<0), (a_lo,b_hi,<<W_W), (a_hi,b_lo,<<I_W), (a_hi,b_hi,<<I_W+W_W).
  - mode1 uses passes 0,1; mode2 uses all four.
  - Signedness: hi halves are signed iff their flag is set; lo halves are always unsigned. In mode0 and mode1 the single a half is signed iff a_s; in mode0 the single b half is signed iff b_s.
  - Each product is sign- or zero-extended to RES_W and added modulo 2^RES_W (wrap, no saturation).
- Weight pointer: advances after the last pass of each input, by 1 in mode0 and by 2 in modes 1/2, modulo W_D.
- Weight load: W_en is honoured only in S_IDLE with count==0; otherwise it is ignored. When honoured: word0<=W_in, word[i]<=word[i-1], ptr<=0.
- Reset mid-operation aborts the group; partial results are discarded.
- in_valid and out_ready are not both relevant in the same state, so no simultaneous-event conflict exists.

Decomposition:
- Package mac_mp_pkg: mode_e enum (MODE_8x8, MODE_8x16, MODE_16x16), state_e enum (S_IDLE, S_MUL, S_OUT), function passes_for_mode, function returning the pass shift amount and the half-select for each pass.
- Sub-module mac_mp_lane: weight store, ptr-indexed read, partial-product multiplier, shifter, accumulator. It is instantiated LANES times.
- The top level holds the FSM, pass/group counters and the mode/flag latches.

Test Plan:
- 8x8 signed: load lane0 weights 5,5,5,5; mode=0, a_s=b_s=1, acc_len=1, in_data lane0=0xFD (-3) -> out_valid 2 cycles after accept, res_out lane0=0xFFFFFFF1.
- 16x16 signed: load weights 0x01,0x2C (word0=0x2C, word1=0x01), mode=2, a_s=b_s=1, in=0xFF38 -> 4 MUL cycles, res=0xFFFF15A0 (-60000).
- Accumulate: mode=0 unsigned, weights 2,2,2,2, acc_len=4, inputs 1,2,3,4 -> single out_valid, res=20; ptr wraps to 0 afterwards.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid=1, in_ready=0 and res_out constant throughout; on out_ready=1, next cycle out_valid=0 and in_ready=1 with accumulator cleared.
- Weight cascade: shift W_in 1,2,3,4 -> W_out=1. W_en pulsed during S_MUL -> weights unchanged.
- Reset asserted during S_MUL pass 2 of a mode2 group -> all outputs return to reset values immediately; the next group computes correctly from count=0.
